// File: rtl/accum_stream_source.sv
// Framed stream source: a DEPTH-word FIFO that is drained in len x frames word
// transfers, with a registered output stage and a one-cycle done pulse.
module accum_stream_source #(
  parameter int FRAC_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 16,
  localparam int DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic [DATA_WIDTH-1:0] wrDataIn,
  input  logic                  wrValidIn,
  output logic                  wrReadyOut,
  input  logic [LEN_WIDTH-1:0]  lenIn,
  input  logic [LEN_WIDTH-1:0]  framesIn,
  input  logic                  startIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  lastOut,
  output logic                  busyOut,
  output logic                  doneOut
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state, nextState;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wrPtr, rdPtr;
  logic [AW:0]           count;
  logic [LEN_WIDTH-1:0]  lenReg, framesReg, wordCnt, frameCnt;
  logic                  wrEn, pop, wordLast, frameLast;

  assign wrReadyOut = (count < (AW+1)'(DEPTH));
  assign wrEn       = wrValidIn & wrReadyOut;
  assign pop        = (state == STREAM) && (count != '0);
  assign wordLast   = (wordCnt == lenReg - LEN_WIDTH'(1));
  assign frameLast  = (frameCnt == framesReg - LEN_WIDTH'(1));

  always_ff @(posedge clkIn) begin
    if (wrEn) mem[wrPtr] <= wrDataIn;
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({wrEn, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startIn) begin
          if (lenIn != '0 && framesIn != '0) nextState = STREAM;
          else                               nextState = DONE;
        end
      end
      STREAM:  if (pop && wordLast && frameLast) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busyOut = (state == STREAM);
    doneOut = (state == DONE);
  end

  // Counters only advance on a pop, so empty-FIFO bubbles leave them untouched.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      lenReg    <= '0;
      framesReg <= '0;
      wordCnt   <= '0;
      frameCnt  <= '0;
    end else if (state == IDLE && startIn) begin
      lenReg    <= lenIn;
      framesReg <= framesIn;
      wordCnt   <= '0;
      frameCnt  <= '0;
    end else if (pop) begin
      if (wordLast) begin
        wordCnt  <= '0;
        frameCnt <= frameCnt + LEN_WIDTH'(1);
      end else begin
        wordCnt  <= wordCnt + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      dataOut  <= '0;
      validOut <= 1'b0;
      lastOut  <= 1'b0;
    end else begin
      if (pop) dataOut <= mem[rdPtr];
      validOut <= pop;
      lastOut  <= pop & wordLast;
    end
  end

endmodule

// File: tb/tb_accum_stream_source.sv
// Scoreboard bench for accum_stream_source: expected words are queued as they
// are written and checked against the output stream by a negedge monitor.
module tb_accum_stream_source;

  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 8;

  logic          clkIn = 1'b0;
  logic          rstIn;
  logic [DW-1:0] wrDataIn;
  logic          wrValidIn;
  logic          wrReadyOut;
  logic [LW-1:0] lenIn, framesIn;
  logic          startIn;
  logic [DW-1:0] dataOut;
  logic          validOut, lastOut, busyOut, doneOut;

  accum_stream_source #(.FRAC_WIDTH(24), .EXP_WIDTH(8), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .wrDataIn(wrDataIn), .wrValidIn(wrValidIn),
    .wrReadyOut(wrReadyOut), .lenIn(lenIn), .framesIn(framesIn), .startIn(startIn),
    .dataOut(dataOut), .validOut(validOut), .lastOut(lastOut), .busyOut(busyOut),
    .doneOut(doneOut)
  );

  always #5 clkIn = ~clkIn;

  int cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;
  logic [DW:0] expQ [$];
  int nValid, firstCyc, lastCyc, doneCyc, startCyc;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clkIn) begin
    if (validOut === 1'b1) begin
      if (expQ.size() == 0) begin
        checkEq("unexpectedWord", 1, 0);
      end else begin
        logic [DW:0] e;
        e = expQ.pop_front();
        checkEq("data", dataOut, e[DW-1:0]);
        checkEq("last", lastOut, e[DW]);
      end
      if (nValid == 0) firstCyc = cyc;
      lastCyc = cyc;
      nValid++;
    end
    if (doneOut === 1'b1) doneCyc = cyc;
  end

  task automatic step;
    @(posedge clkIn); #1;
  endtask

  task automatic clearRec;
    nValid = 0; firstCyc = -1; lastCyc = -1; doneCyc = -1;
  endtask

  task automatic doReset;
    rstIn = 1'b0; wrValidIn = 1'b0; startIn = 1'b0;
    step;
    checkEq("rstValid", validOut, 0);
    checkEq("rstLast", lastOut, 0);
    checkEq("rstBusy", busyOut, 0);
    checkEq("rstDone", doneOut, 0);
    checkEq("rstData", dataOut, 0);
    checkEq("rstReady", wrReadyOut, 1);
    step;
    rstIn = 1'b1;
    expQ.delete();
    clearRec();
  endtask

  task automatic writeWord(input logic [DW-1:0] w);
    wrDataIn = w; wrValidIn = 1'b1;
    step;
    wrValidIn = 1'b0;
  endtask

  task automatic pushExp(input logic [DW-1:0] w, input logic last);
    expQ.push_back({last, w});
  endtask

  task automatic startXfer(input int len, input int frames);
    clearRec();
    lenIn = LW'(len); framesIn = LW'(frames); startIn = 1'b1;
    startCyc = cyc;
    step;
    startIn = 1'b0;
  endtask

  task automatic stepTo(input int target);
    for (int i = 0; i < 100 && cyc < target; i++) step;
  endtask

  // Busy must hold from the cycle after start until the DONE cycle.
  task automatic waitDone(input int limit, input bit chkBusy);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (doneOut) seen = 1'b1;
      else begin
        if (chkBusy) checkEq("busyHigh", busyOut, 1);
        step;
      end
    end
    checkEq("doneSeen", seen, 1);
    if (seen) begin
      checkEq("busyInDone", busyOut, 0);
      step;
      checkEq("donePulse1", doneOut, 0);
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] fw [4];
    fw[0] = 32'h3F800000; fw[1] = 32'h40000000; fw[2] = 32'h40400000; fw[3] = 32'h40800000;
    rstIn = 1'b0; wrDataIn = '0; wrValidIn = 1'b0; lenIn = '0; framesIn = '0; startIn = 1'b0;
    clearRec();
    doReset();

    // 1.0..4.0 as one frame of four
    for (int i = 0; i < 4; i++) begin writeWord(fw[i]); pushExp(fw[i], i == 3); end
    startXfer(4, 1);
    waitDone(20, 1);
    checkEq("t1Count", nValid, 4);
    checkEq("t1First", firstCyc, startCyc + 2);
    checkEq("t1Back2Back", lastCyc - firstCyc, 3);
    checkEq("t1DoneCyc", doneCyc, lastCyc);
    checkEq("t1QEmpty", expQ.size(), 0);

    // two frames of three, plus retention of leftover words
    doReset();
    for (int i = 0; i < 7; i++) begin
      w = $urandom;
      writeWord(w);
      if (i < 6) pushExp(w, (i % 3) == 2);
      else       fw[0] = w;
    end
    startXfer(3, 2);
    checkEq("t2StartIgnored", busyOut, 1);
    startIn = 1'b1; lenIn = 16'd1; framesIn = 16'd1;
    waitDone(30, 1);
    startIn = 1'b0;
    checkEq("t2Count", nValid, 6);
    pushExp(fw[0], 1'b1);
    startXfer(1, 1);
    waitDone(10, 1);
    checkEq("t2Retained", nValid, 1);

    // empty FIFO at start, words trickle in mid-stream
    doReset();
    startXfer(2, 1);
    stepTo(startCyc + 5);
    w = 32'hA5A5_0001; pushExp(w, 1'b0); writeWord(w);
    stepTo(startCyc + 9);
    w = 32'hA5A5_0002; pushExp(w, 1'b1); writeWord(w);
    waitDone(20, 1);
    checkEq("t3Count", nValid, 2);
    checkEq("t3First", firstCyc, startCyc + 7);
    checkEq("t3Last", lastCyc, startCyc + 11);
    checkEq("t3DoneCyc", doneCyc, startCyc + 11);

    // overfill while idle
    doReset();
    wrValidIn = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = $urandom;
      wrDataIn = w;
      checkEq("fillReady", wrReadyOut, (i < DEPTH) ? 1 : 0);
      if (i < DEPTH) pushExp(w, i == DEPTH - 1);
      step;
    end
    wrValidIn = 1'b0;
    checkEq("fullReady", wrReadyOut, 0);
    startXfer(DEPTH, 1);
    waitDone(40, 1);
    checkEq("t4Count", nValid, DEPTH);
    checkEq("t4ReadyAfter", wrReadyOut, 1);
    checkEq("t4QEmpty", expQ.size(), 0);

    // zero length / zero frames skip straight to DONE
    doReset();
    startXfer(0, 5);
    checkEq("t5DoneNext", doneOut, 1);
    waitDone(5, 0);
    checkEq("t5DoneCyc", doneCyc, startCyc + 1);
    startXfer(3, 0);
    waitDone(5, 0);
    checkEq("t5NoWords", nValid, 0);
    w = 32'h3F800000; writeWord(w); pushExp(w, 1'b1);
    startXfer(1, 1);
    waitDone(10, 1);
    checkEq("t5OneWord", nValid, 1);

    // reset in the middle of a frame
    doReset();
    for (int i = 0; i < 4; i++) begin w = $urandom; writeWord(w); pushExp(w, i == 3); end
    startXfer(4, 1);
    for (int i = 0; i < 20 && nValid < 2; i++) begin @(negedge clkIn); #1; end
    checkEq("t6TwoSeen", nValid, 2);
    rstIn = 1'b0;
    step;
    checkEq("t6Valid", validOut, 0);
    checkEq("t6Done", doneOut, 0);
    checkEq("t6Busy", busyOut, 0);
    checkEq("t6Data", dataOut, 0);
    checkEq("t6Ready", wrReadyOut, 1);
    step;
    checkEq("t6Done2", doneOut, 0);
    rstIn = 1'b1;
    expQ.delete();
    startXfer(1, 1);
    for (int i = 0; i < 4; i++) step;
    checkEq("t6FifoEmpty", nValid, 0);
    w = 32'h4120_0000; pushExp(w, 1'b1); writeWord(w);
    waitDone(10, 1);
    checkEq("t6After", nValid, 1);
    checkEq("t6NoDoneDuringRst", doneCyc, lastCyc);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
